// File: rtl/conv_pkg.sv
// Shared pixel types and helpers for the convolution front end.
package conv_pkg;

    localparam int DEFAULT_KERNEL_SIZE = 3;
    localparam int DEFAULT_WORD_SIZE   = 16;

    typedef struct packed {
        logic signed [DEFAULT_WORD_SIZE-1:0] r;
        logic signed [DEFAULT_WORD_SIZE-1:0] g;
        logic signed [DEFAULT_WORD_SIZE-1:0] b;
    } pixel_t;

    function automatic logic [3*DEFAULT_WORD_SIZE-1:0] pack_pixel(input pixel_t p);
        return {p.r, p.g, p.b};
    endfunction

    function automatic pixel_t unpack_pixel(input logic [3*DEFAULT_WORD_SIZE-1:0] v);
        pixel_t p;
        p.r = v[3*DEFAULT_WORD_SIZE-1:2*DEFAULT_WORD_SIZE];
        p.g = v[2*DEFAULT_WORD_SIZE-1:DEFAULT_WORD_SIZE];
        p.b = v[DEFAULT_WORD_SIZE-1:0];
        return p;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One image row of pixel storage: combinational read, synchronous write.
// A write in the same cycle as a read returns the old contents (read-before-write).
module line_ram
    import conv_pkg::*;
#(
    parameter int  DEPTH = 640,
    parameter int  WIDTH = 3*DEFAULT_WORD_SIZE,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    // Storage is deliberately unreset; stale entries are masked by the window-position rule.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_line_buffer.sv
// Raster-stream to KxK window generator for the "valid" convolution region.
// Optional WINDOW_SOF_RESYNC_EN adds in_sof to force the accepted pixel to (0,0).
module window_line_buffer
    import conv_pkg::*;
#(
    parameter int  KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
    parameter int  WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int  IMG_WIDTH   = 640,
    parameter int  IMG_HEIGHT  = 480,
    localparam int PW          = 3*WORD_SIZE,
    localparam int RW          = $clog2(IMG_HEIGHT),
    localparam int CW          = $clog2(IMG_WIDTH)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [PW-1:0]                                  in_pixel,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PW-1:0] win_out,
    output logic                                           win_valid,
    input  logic                                           win_ready,
    output logic [RW-1:0]                                  win_row,
    output logic [CW-1:0]                                  win_col,
    output logic                                           frame_done
`ifdef WINDOW_SOF_RESYNC_EN
    ,
    input  logic                                           in_sof
`endif
);

    logic [RW-1:0] row_q, row_d, cur_row_s, out_row_q, out_row_d;
    logic [CW-1:0] col_q, col_d, cur_col_s, out_col_q, out_col_d;
    logic          valid_q, valid_d, done_q, done_d;
    logic          accept_s, sof_s, last_col_s, last_row_s, qualify_s;
    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PW-1:0] win_q, win_d;
    logic [PW-1:0] lb_rd_s [KERNEL_SIZE-1];

`ifdef WINDOW_SOF_RESYNC_EN
    assign sof_s = in_sof;
`else
    assign sof_s = 1'b0;
`endif

    assign in_ready   = !valid_q || win_ready;
    assign accept_s   = in_valid && in_ready;
    assign cur_row_s  = sof_s ? {RW{1'b0}} : row_q;
    assign cur_col_s  = sof_s ? {CW{1'b0}} : col_q;
    assign last_col_s = (cur_col_s == CW'(IMG_WIDTH-1));
    assign last_row_s = (cur_row_s == RW'(IMG_HEIGHT-1));
    assign qualify_s  = (cur_row_s >= RW'(KERNEL_SIZE-1)) && (cur_col_s >= CW'(KERNEL_SIZE-1));

    // Line buffer i holds the row i+1 rows above the incoming one; each shifts into the next.
    for (genvar i = 0; i < KERNEL_SIZE-1; i++) begin : g_lb
        logic [PW-1:0] wdata_s;
        if (i == 0) begin : g_first
            assign wdata_s = in_pixel;
        end else begin : g_rest
            assign wdata_s = lb_rd_s[i-1];
        end
        line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_ram (
            .clk   (clk),
            .addr  (cur_col_s),
            .we    (accept_s),
            .wdata (wdata_s),
            .rdata (lb_rd_s[i])
        );
    end

    // Raster position counters.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept_s) begin
            if (last_col_s) begin
                col_d = {CW{1'b0}};
                row_d = last_row_s ? {RW{1'b0}} : cur_row_s + RW'(1);
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Window shift: every row moves left, the new right column comes from the line buffers.
    always_comb begin
        win_d = win_q;
        if (accept_s) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            win_d[KERNEL_SIZE-1][KERNEL_SIZE-1] = in_pixel;
            for (int i = 0; i < KERNEL_SIZE-1; i++) begin
                win_d[KERNEL_SIZE-2-i][KERNEL_SIZE-1] = lb_rd_s[i];
            end
        end else begin
            win_d = win_q;
        end
    end

    // Output handshake state; a stalled window holds because no accept can occur.
    always_comb begin
        valid_d   = valid_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        done_d    = accept_s && last_row_s && last_col_s;
        if (accept_s) begin
            valid_d   = qualify_s;
            out_row_d = cur_row_s;
            out_col_d = cur_col_s;
        end else if (win_ready) begin
            valid_d   = 1'b0;
        end else begin
            valid_d   = valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q     <= {RW{1'b0}};
            col_q     <= {CW{1'b0}};
            out_row_q <= {RW{1'b0}};
            out_col_q <= {CW{1'b0}};
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= '0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            win_q     <= win_d;
        end
    end

    assign win_out    = win_q;
    assign win_valid  = valid_q;
    assign win_row    = out_row_q;
    assign win_col    = out_col_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_window_line_buffer.sv
// Randomized/directed bench for window_line_buffer (K=3, 8x6 image) against an image-array model.
module tb_window_line_buffer;

    localparam int K = 3;
    localparam int W = 8;
    localparam int H = 6;

    logic                     clk;
    logic                     reset;
    logic [47:0]              in_pixel;
    logic                     in_valid;
    logic                     in_ready;
    logic [K-1:0][K-1:0][47:0] win_out;
    logic                     win_valid;
    logic                     win_ready;
    logic [2:0]               win_row;
    logic [2:0]               win_col;
    logic                     frame_done;
`ifdef WINDOW_SOF_RESYNC_EN
    logic                     in_sof_v;
`endif

    window_line_buffer #(
        .KERNEL_SIZE(K), .WORD_SIZE(16), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
`ifdef WINDOW_SOF_RESYNC_EN
        ,
        .in_sof     (in_sof_v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int obs_win = 0;
    int obs_fd  = 0;

    // Reference model: the image as written so far plus the expected output registers.
    logic [47:0] img [H][W];
    logic [47:0] m_win [K][K];
    bit          m_valid;
    bit          m_fd;
    int          m_row, m_col;
    int          cnt_r, cnt_c;

    function automatic logic [47:0] pix(input int r, input int c);
        return {16'(r), 16'(c), 16'(r*W + c)};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_fd    = 1'b0;
        m_row   = 0;
        m_col   = 0;
        cnt_r   = 0;
        cnt_c   = 0;
    endtask

    // One clock: drive at posedge+1, check ready, advance model at the edge, check outputs at edge+1.
    task automatic cycle(input bit v, input logic [47:0] p, input bit wr, input bit sof, output bit acc);
        bit rdy_exp;
        int r, c;
        in_valid  = v;
        in_pixel  = p;
        win_ready = wr;
`ifdef WINDOW_SOF_RESYNC_EN
        in_sof_v  = sof;
`endif
        #1;
        rdy_exp = !m_valid || wr;
        chk("in_ready", {47'd0, in_ready}, {47'd0, rdy_exp});
        acc = v && rdy_exp;
        if (win_valid === 1'b1 && wr) obs_win++;
        @(posedge clk);
        m_fd = 1'b0;
        if (acc) begin
            if (sof) begin
                cnt_r = 0;
                cnt_c = 0;
            end
            r = cnt_r;
            c = cnt_c;
            img[r][c] = p;
            m_valid = (r >= K-1) && (c >= K-1);
            if (m_valid) begin
                m_row = r;
                m_col = c;
                for (int a = 0; a < K; a++)
                    for (int b = 0; b < K; b++)
                        m_win[a][b] = img[r-(K-1)+a][c-(K-1)+b];
            end
            m_fd = (r == H-1) && (c == W-1);
            cnt_c = (c == W-1) ? 0 : c + 1;
            cnt_r = (c == W-1) ? ((r == H-1) ? 0 : r + 1) : r;
        end else if (wr) begin
            m_valid = 1'b0;
        end
        #1;
        chk("win_valid", {47'd0, win_valid}, {47'd0, m_valid});
        chk("frame_done", {47'd0, frame_done}, {47'd0, m_fd});
        if (frame_done === 1'b1) obs_fd++;
        if (m_valid) begin
            chk("win_row", {45'd0, win_row}, 48'(m_row));
            chk("win_col", {45'd0, win_col}, 48'(m_col));
            for (int a = 0; a < K; a++)
                for (int b = 0; b < K; b++)
                    chk($sformatf("win_out[%0d][%0d]", a, b), win_out[a][b], m_win[a][b]);
        end
    endtask

    task automatic send(input logic [47:0] p, input int gap_pct, input int nr_pct, input bit sof);
        bit acc = 1'b0;
        int n = 0;
        bit v, wr;
        while (!acc && n < 200) begin
            v  = ($urandom_range(0, 99) >= gap_pct);
            wr = ($urandom_range(0, 99) >= nr_pct);
            cycle(v, p, wr, sof, acc);
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $error("FAIL send_timeout: observed=no accept expected=accept within 200 cycles");
        end
    endtask

    task automatic drain();
        bit acc;
        cycle(1'b0, 48'd0, 1'b1, 1'b0, acc);
    endtask

    // Stream a full frame; formula pixels get the directed spot checks.
    task automatic frame(input bit rnd, input int gap, input int nr, input bit bp, input bit sof_first);
        logic [47:0] p;
        bit acc;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p = rnd ? {16'($urandom), 16'($urandom), 16'($urandom)} : pix(r, c);
                if (bp && r == 2 && c == 5) begin
                    for (int k = 0; k < 3; k++) begin
                        cycle(1'b1, p, 1'b0, 1'b0, acc);
                        chk("bp_row", {45'd0, win_row}, 48'd2);
                        chk("bp_col", {45'd0, win_col}, 48'd4);
                        chk("bp_no_accept", {47'd0, acc}, 48'd0);
                    end
                end
                send(p, gap, nr, sof_first && r == 0 && c == 0);
                if (!rnd && r == 2 && c == 2) begin
                    chk("first_w00", win_out[0][0], 48'h0);
                    chk("first_w22", win_out[2][2], {16'd2, 16'd2, 16'd18});
                    chk("first_w11", win_out[1][1], {16'd1, 16'd1, 16'd9});
                    chk("first_valid", {47'd0, win_valid}, 48'd1);
                end
                if (!rnd && r == 4 && c == 2) begin
                    chk("wrap_w20", win_out[2][0], {16'd4, 16'd0, 16'd32});
                    chk("wrap_row", {45'd0, win_row}, 48'd4);
                end
            end
        end
    endtask

    initial begin
        int w0, f0;
        bit acc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = 48'd0;
        win_ready = 1'b1;
`ifdef WINDOW_SOF_RESYNC_EN
        in_sof_v  = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_win_valid", {47'd0, win_valid}, 48'd0);
        chk("rst_frame_done", {47'd0, frame_done}, 48'd0);
        chk("rst_win_row", {45'd0, win_row}, 48'd0);
        chk("rst_win_col", {45'd0, win_col}, 48'd0);
        chk("rst_in_ready", {47'd0, in_ready}, 48'd1);
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                chk("rst_win_out", win_out[a][b], 48'd0);

        // Frame 1: formula pixels with a 3-cycle consumer stall at window (2,4).
        w0 = obs_win; f0 = obs_fd;
        frame(1'b0, 0, 0, 1'b1, 1'b0);
        drain();
        chk("frame1_windows", 48'(obs_win - w0), 48'd24);
        chk("frame1_done", 48'(obs_fd - f0), 48'd1);

        // Two back-to-back random frames with input bubbles and random stalls.
        w0 = obs_win; f0 = obs_fd;
        frame(1'b1, 50, 25, 1'b0, 1'b0);
        frame(1'b1, 50, 25, 1'b0, 1'b0);
        drain();
        chk("bubble_windows", 48'(obs_win - w0), 48'd48);
        chk("bubble_done", 48'(obs_fd - f0), 48'd2);

        // Reset while presenting pixel (3,3), then restart from (0,0).
        for (int i = 0; i < 3*W + 3; i++) send(pix(i / W, i % W), 0, 0, 1'b0);
        in_valid  = 1'b1;
        in_pixel  = pix(3, 3);
        win_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("midrst_win_valid", {47'd0, win_valid}, 48'd0);
        chk("midrst_win_row", {45'd0, win_row}, 48'd0);
        chk("midrst_win_col", {45'd0, win_col}, 48'd0);
        w0 = obs_win; f0 = obs_fd;
        frame(1'b0, 0, 0, 1'b0, 1'b0);
        drain();
        chk("restart_windows", 48'(obs_win - w0), 48'd24);
        chk("restart_done", 48'(obs_fd - f0), 48'd1);

`ifdef WINDOW_SOF_RESYNC_EN
        // Abort after 20 pixels; the 21st carries in_sof and becomes (0,0).
        w0 = obs_win; f0 = obs_fd;
        for (int i = 0; i < 20; i++) send(pix(i / W, i % W), 0, 0, 1'b0);
        frame(1'b0, 0, 0, 1'b0, 1'b1);
        drain();
        chk("sof_windows", 48'(obs_win - w0), 48'd26);
        chk("sof_done", 48'(obs_fd - f0), 48'd1);
`endif

        cycle(1'b0, 48'd0, 1'b1, 1'b0, acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
